aemb2_uram: RTL



---
 rtl/aemb2_uram_pkg.sv | 28 ++
 rtl/aemb2_uram_arb.sv | 39 +++
 rtl/aemb2_uram_spsram.sv | 28 ++
 rtl/aemb2_uram.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/aemb2_uram_pkg.sv
// aemb2_uram shared definitions: FSM state encodings, port indices and the
// wait-state counter width. The OREG state exists only when the
// AEMB2_URAM_OREG_EN macro is defined (output register build).
package aemb2_uram_pkg;

`ifdef AEMB2_URAM_OREG_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2,
      ST_OREG = 2'd3
   } state_e;
`else
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_e;
`endif

   // Port indices into request/grant vectors {dwb, iwb}
   localparam int IWB = 0;
   localparam int DWB = 1;

   // Wait-state counter width (WS legal range 0..15)
   localparam int WSW = 4;

endpackage

// File: rtl/aemb2_uram_arb.sv
// aemb2_uram_arb: two-port round-robin arbiter. A single requester always
// wins; on a tie the port that was not granted last wins. The last-grant
// flag resets to iwb so dwb wins the first tie.
module aemb2_uram_arb
   import aemb2_uram_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,   // {dwb, iwb}
   input  logic       take,  // grant is being consumed this cycle
   output logic [1:0] gnt    // one-hot winner
);

   logic last_q, last_d;     // 1: dwb granted last, 0: iwb granted last

   // Winner selection
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_q ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   // Last-grant update only when a grant actually commits
   always_comb begin
      last_d = last_q;
      if (take && (|gnt)) last_d = gnt[DWB];
   end

   // Last-grant register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= 1'b0;
      else        last_q <= last_d;
   end

endmodule

// File: rtl/aemb2_uram_spsram.sv
// aeMB2_spsram: single-port synchronous SRAM, one byte lane of aemb2_uram.
// Registered read; the output holds whenever the lane is not enabled.
module aeMB2_spsram #(
   parameter int AW = 12,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          ena,
   input  logic          wre,
   input  logic [AW-1:0] adr,
   input  logic [DW-1:0] dat_i,
   output logic [DW-1:0] dat_o
);

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] dat_q;

   // Storage and read register; contents are never reset
   always_ff @(posedge clk) begin
      if (ena) begin
         if (wre) mem[adr] <= dat_i;
         dat_q <= mem[adr];
      end
   end

   assign dat_o = dat_q;

endmodule

// File: rtl/aemb2_uram.sv
// aemb2_uram: unified single-port Wishbone memory serving the aeMB2 iwb and
// dwb ports from one byte-lane SRAM. Round-robin arbitration, WS wait states,
// one-cycle IDLE bubble after every ack.
// Optional macro AEMB2_URAM_OREG_EN: registers read data and adds one cycle
// of latency before ack.
module aemb2_uram
   import aemb2_uram_pkg::*;
#(
   parameter int AW = 14,
   parameter int WS = 0
) (
   input  logic          sys_clk_i,
   input  logic          sys_rst_ni,
   input  logic [AW-3:0] iwb_adr_o,
   input  logic [3:0]    iwb_sel_o,
   input  logic          iwb_stb_o,
   input  logic          iwb_wre_o,
   input  logic [31:0]   iwb_dat_o,
   output logic [31:0]   iwb_dat_i,
   output logic          iwb_ack_i,
   input  logic [AW-3:0] dwb_adr_o,
   input  logic [3:0]    dwb_sel_o,
   input  logic          dwb_stb_o,
   input  logic          dwb_wre_o,
   input  logic [31:0]   dwb_dat_o,
   output logic [31:0]   dwb_dat_i,
   output logic          dwb_ack_i
);

   localparam logic [WSW-1:0] WS_LD = (WS > 0) ? WSW'(WS - 1) : '0;

`ifdef AEMB2_URAM_OREG_EN
   localparam state_e ST_POST = ST_OREG;
`else
   localparam state_e ST_POST = ST_ACK;
`endif

   state_e         state_q, state_d;
   logic [WSW-1:0] cnt_q, cnt_d;
   logic [1:0]     gnt_q, gnt_d;
   logic           bubble_q, bubble_d;   // set for the IDLE cycle after ACK
   logic [1:0]     req, gnt;
   logic           take;

   logic           ena, wre;
   logic [AW-3:0]  adr;
   logic [31:0]    wdat, ram_dat, rdat;
   logic [3:0]     sel;

   // No grant during the bubble, so a stb released on ack is never re-sampled
   assign req = bubble_q ? 2'b00 : {dwb_stb_o, iwb_stb_o};

   aemb2_uram_arb u_arb (
      .clk   (sys_clk_i),
      .rst_n (sys_rst_ni),
      .req   (req),
      .take  (take),
      .gnt   (gnt)
   );

   // Next-state, wait counter and grant capture
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gnt_d    = gnt_q;
      bubble_d = 1'b0;
      take     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req) begin
               take    = 1'b1;
               gnt_d   = gnt;
               cnt_d   = WS_LD;
               state_d = (WS > 0) ? ST_WAIT : ST_POST;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) state_d = ST_POST;
            else             cnt_d   = cnt_q - WSW'(1);
         end
`ifdef AEMB2_URAM_OREG_EN
         ST_OREG: state_d = ST_ACK;
`endif
         ST_ACK: begin
            state_d  = ST_IDLE;
            bubble_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM registers
   always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
      if (!sys_rst_ni) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         gnt_q    <= 2'b00;
         bubble_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         bubble_q <= bubble_d;
      end
   end

   // SRAM controls come straight from the winner in the grant cycle
   always_comb begin
      ena = take;
      if (gnt[DWB]) begin
         adr  = dwb_adr_o;
         sel  = dwb_sel_o;
         wdat = dwb_dat_o;
         wre  = take & dwb_wre_o;
      end else begin
         adr  = iwb_adr_o;
         sel  = iwb_sel_o;
         wdat = iwb_dat_o;
         wre  = take & iwb_wre_o;
      end
   end

   for (genvar n = 0; n < 4; n++) begin : g_lane
      aeMB2_spsram #(AW-2, 8) u_lane (
         .clk   (sys_clk_i),
         .ena   (ena & sel[n]),
         .wre   (wre),
         .adr   (adr),
         .dat_i (wdat[8*n +: 8]),
         .dat_o (ram_dat[8*n +: 8])
      );
   end

`ifdef AEMB2_URAM_OREG_EN
   logic [31:0] oreg_q, oreg_d;

   // Output register loads in the cycle before ACK
   always_comb begin
      oreg_d = oreg_q;
      if (state_q == ST_OREG) oreg_d = ram_dat;
   end

   // Output data register
   always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
      if (!sys_rst_ni) oreg_q <= '0;
      else             oreg_q <= oreg_d;
   end

   assign rdat = oreg_q;
`else
   assign rdat = ram_dat;
`endif

   assign iwb_dat_i = rdat;
   assign dwb_dat_i = rdat;
   assign iwb_ack_i = (state_q == ST_ACK) & gnt_q[IWB];
   assign dwb_ack_i = (state_q == ST_ACK) & gnt_q[DWB];

endmodule
